// File: rtl/spi_slave.sv
// spi_slave: SPI responder, CPHA=0, MSB-first, CPOL selectable.
// SCK/SS/SI are oversampled in the clk domain. The processor side has a
// control reg, a status reg and tx/rx buffers.
// Ports:
//   i_clk, i_rst_n               clock, synchronous active-low reset
//   i_sconEN, i_sconIN[7:0]      control write ([7]=enable, [0]=CPOL)
//   i_statREAD, o_statOUT[7:0]   status {4'b0, ACT, TXE, OVR, BF}; read clears OVR
//   i_wrBUF, i_bufIN[DW-1:0]     tx buffer load
//   i_rdBUF, o_bufOUT[DW-1:0]    rx buffer, rdBUF clears BF
//   i_SCK, i_SS, i_SI            async bus inputs
//   o_SO, o_SOE                  serial out and its drive enable
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sconEN,
  input  logic [7:0]    i_sconIN,
  input  logic          i_statREAD,
  output logic [7:0]    o_statOUT,
  input  logic          i_wrBUF,
  input  logic [DW-1:0] i_bufIN,
  input  logic          i_rdBUF,
  output logic [DW-1:0] o_bufOUT,
  input  logic          i_SCK,
  input  logic          i_SS,
  input  logic          i_SI,
  output logic          o_SO,
  output logic          o_SOE
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_ss_sync, r_si_sync;
  logic                   r_sck_d;

  state_t         r_state;
  logic [7:0]     r_ctrl;
  logic [DW-1:0]  r_txbuf, r_tx_sh, r_rx_sh, r_bufout;
  logic [CW-1:0]  r_cnt;
  logic           r_txe, r_ovr, r_bf, r_so, r_reload;

  logic           w_sck, w_ss, w_si, w_rise, w_fall, w_lead, w_trail, w_sel;
  logic [DW-1:0]  w_tx_next;

  // SS resets high so the bus looks deselected until the synchroniser fills.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sck_sync <= '0;
      r_ss_sync  <= '1;
      r_si_sync  <= '0;
      r_sck_d    <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], i_SCK};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], i_SS};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], i_SI};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck   = r_sck_sync[SYNC_STAGES-1];
  assign w_ss    = r_ss_sync[SYNC_STAGES-1];
  assign w_si    = r_si_sync[SYNC_STAGES-1];
  assign w_rise  = w_sck & ~r_sck_d;
  assign w_fall  = ~w_sck & r_sck_d;
  assign w_lead  = r_ctrl[0] ? w_fall : w_rise;
  assign w_trail = r_ctrl[0] ? w_rise : w_fall;
  assign w_sel   = r_ctrl[7] & ~w_ss;
  // Underrun sends zeros rather than repeating the last byte.
  assign w_tx_next = r_txe ? '0 : r_txbuf;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_txbuf  <= '0;
      r_tx_sh  <= '0;
      r_rx_sh  <= '0;
      r_bufout <= '0;
      r_cnt    <= '0;
      r_txe    <= 1'b1;
      r_ovr    <= 1'b0;
      r_bf     <= 1'b0;
      r_so     <= 1'b0;
      r_reload <= 1'b0;
    end else begin
      if (i_sconEN)   r_ctrl  <= i_sconIN;
      if (i_statREAD) r_ovr   <= 1'b0;
      if (i_rdBUF)    r_bf    <= 1'b0;
      if (i_wrBUF)    r_txbuf <= i_bufIN;

      case (r_state)
        S_IDLE: begin
          r_cnt    <= '0;
          r_reload <= 1'b0;
          if (w_sel) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (!w_sel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_so    <= 1'b0;
          end else begin
            r_tx_sh <= w_tx_next;
            r_so    <= w_tx_next[DW-1];
            r_txe   <= 1'b1;
            r_rx_sh <= '0;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_sel) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_so     <= 1'b0;
            r_reload <= 1'b0;
          end else begin
            // Set after the clears above so completion beats a same-cycle rdBUF/statREAD.
            if (r_cnt == CW'(DW)) begin
              if (!r_bf) begin
                r_bufout <= r_rx_sh;
                r_bf     <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
              r_cnt    <= '0;
              r_reload <= 1'b1;
            end
            if (w_lead) begin
              r_rx_sh <= {r_rx_sh[DW-2:0], w_si};
              r_cnt   <= r_cnt + CW'(1);
            end
            if (w_trail) begin
              if (r_reload) begin
                r_tx_sh  <= w_tx_next;
                r_so     <= w_tx_next[DW-1];
                r_txe    <= 1'b1;
                r_reload <= 1'b0;
              end else begin
                r_tx_sh <= {r_tx_sh[DW-2:0], 1'b0};
                r_so    <= r_tx_sh[DW-2];
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A write in the same cycle as a load leaves the new byte pending.
      if (i_wrBUF) r_txe <= 1'b0;
    end
  end

  assign o_statOUT = {4'b0000, w_sel, r_txe, r_ovr, r_bf};
  assign o_bufOUT  = r_bufout;
  assign o_SO      = r_so;
  assign o_SOE     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sconEN = 1'b0;
  logic [7:0] sconIN = '0;
  logic       statREAD = 1'b0;
  logic [7:0] statOUT;
  logic       wrBUF = 1'b0;
  logic [7:0] bufIN = '0;
  logic       rdBUF = 1'b0;
  logic [7:0] bufOUT;
  logic       SCK = 1'b0;
  logic       SS = 1'b1;
  logic       SI = 1'b0;
  logic       SO, SOE;

  int n_vec = 0;
  int n_err = 0;
  logic       cpol = 1'b0;
  logic [7:0] mi, mi2;
  logic [7:0] exp_so_q[$];
  logic [7:0] exp_rx_q[$];

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2), .DW(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_sconEN(sconEN), .i_sconIN(sconIN),
    .i_statREAD(statREAD), .o_statOUT(statOUT),
    .i_wrBUF(wrBUF), .i_bufIN(bufIN),
    .i_rdBUF(rdBUF), .o_bufOUT(bufOUT),
    .i_SCK(SCK), .i_SS(SS), .i_SI(SI),
    .o_SO(SO), .o_SOE(SOE)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scon(input logic [7:0] v);
    sconIN = v; sconEN = 1'b1; wait_clk(1); sconEN = 1'b0; wait_clk(1);
  endtask

  task automatic wrbuf(input logic [7:0] v);
    bufIN = v; wrBUF = 1'b1; wait_clk(1); wrBUF = 1'b0;
  endtask

  task automatic rdbuf();
    rdBUF = 1'b1; wait_clk(1); rdBUF = 1'b0; wait_clk(1);
  endtask

  task automatic statread();
    statREAD = 1'b1; wait_clk(1); statREAD = 1'b0; wait_clk(1);
  endtask

  // Master side: CPHA=0, sample MI just before the leading edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      SI = mo[7-i];
      wait_clk(6);
      rx = {rx[6:0], SO};
      SCK = ~cpol;
      wait_clk(6);
      SCK = cpol;
    end
    wait_clk(6);
  endtask

  task automatic ss_low();
    SS = 1'b0; wait_clk(6);
  endtask

  task automatic ss_high();
    SS = 1'b1; wait_clk(6);
  endtask

  initial begin
    // reset
    wait_clk(2);
    check("rst_stat", statOUT, 8'h04);
    check("rst_buf", bufOUT, 8'h00);
    check("rst_soe", {7'b0, SOE}, 8'h00);
    check("rst_so", {7'b0, SO}, 8'h00);
    rst_n = 1'b1;
    wait_clk(2);

    // mode 0, tx 0x3C, rx 0xA5
    scon(8'h80);
    wrbuf(8'h3C);
    check("txe_clr", statOUT, 8'h00);
    exp_so_q.push_back(8'h3C); exp_rx_q.push_back(8'hA5);
    ss_low();
    check("act_soe", {statOUT[3], SOE}, {1'b1, 1'b1});
    xfer(8'hA5, 8, mi);
    ss_high();
    check("m0_so", mi, exp_so_q.pop_front());
    check("m0_buf", bufOUT, exp_rx_q.pop_front());
    check("m0_stat", statOUT, 8'h05);
    check("m0_soe", {7'b0, SOE}, 8'h00);
    rdbuf();
    check("m0_rd", statOUT, 8'h04);

    // CPOL=1, idle-high SCK, no tx data (underrun)
    cpol = 1'b1; SCK = 1'b1; wait_clk(4);
    scon(8'h81);
    exp_so_q.push_back(8'h00); exp_rx_q.push_back(8'h5A);
    ss_low();
    xfer(8'h5A, 8, mi);
    ss_high();
    check("c1_so", mi, exp_so_q.pop_front());
    check("c1_buf", bufOUT, exp_rx_q.pop_front());
    check("c1_stat", statOUT, 8'h05);
    rdbuf();

    // underrun in mode 0
    cpol = 1'b0; SCK = 1'b0; wait_clk(4);
    scon(8'h80);
    exp_so_q.push_back(8'h00); exp_rx_q.push_back(8'h96);
    ss_low();
    xfer(8'h96, 8, mi);
    ss_high();
    check("ur_so", mi, exp_so_q.pop_front());
    check("ur_buf", bufOUT, exp_rx_q.pop_front());
    rdbuf();

    // overrun: two back-to-back bytes, second tx byte written mid-transfer
    wrbuf(8'h81);
    exp_so_q.push_back(8'h81); exp_so_q.push_back(8'h7E);
    exp_rx_q.push_back(8'h11);
    ss_low();
    fork
      xfer(8'h11, 8, mi);
      begin wait_clk(30); wrbuf(8'h7E); end
    join
    xfer(8'h22, 8, mi2);
    ss_high();
    check("ov_so0", mi, exp_so_q.pop_front());
    check("ov_so1", mi2, exp_so_q.pop_front());
    check("ov_buf", bufOUT, exp_rx_q.pop_front());
    check("ov_stat", statOUT, 8'h07);
    statread();
    check("ov_rdstat", statOUT, 8'h05);
    rdbuf();
    check("ov_rdbuf", statOUT, 8'h04);

    // abort after 4 bits, then a clean byte
    ss_low();
    xfer(8'hFF, 4, mi);
    ss_high();
    check("ab_stat", statOUT, 8'h04);
    check("ab_buf", bufOUT, 8'h11);
    exp_rx_q.push_back(8'hC3);
    ss_low();
    xfer(8'hC3, 8, mi);
    ss_high();
    check("ab_newbuf", bufOUT, exp_rx_q.pop_front());
    check("ab_newstat", statOUT, 8'h05);
    rdbuf();

    // disabled: bus ignored
    scon(8'h00);
    ss_low();
    check("dis_act", {statOUT[3], SOE}, 2'b00);
    xfer(8'h99, 8, mi);
    check("dis_soe", {7'b0, SOE}, 8'h00);
    ss_high();
    check("dis_stat", statOUT, 8'h04);
    check("dis_buf", bufOUT, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
